// File: rtl/regfile_pkg.sv
// Shared sizing for the scoreboarded register file: register count, data width,
// register-select width and pending-count width.
package regfile_pkg;
  localparam int NUM_REGS = 8;
  localparam int WIDTH    = 16;
  localparam int SEL_W    = 3;
  localparam int CNT_W    = 2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
endpackage

// File: rtl/regfile_sb_counter.sv
// Per-register saturating pending-write counter (module sb_counter).
// An increment and a decrement in the same cycle cancel out. Overflow and underflow are flagged.
module sb_counter
  import regfile_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_ovf,
  output logic             o_udf
);

  logic [CNT_W-1:0] r_count;

  always_comb begin
    o_ovf = i_inc & ~i_dec & (r_count == CNT_MAX);
    o_udf = i_dec & ~i_inc & (r_count == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && !o_ovf) begin
      r_count <= r_count + 1'b1;
    end else if (i_dec && !i_inc && !o_udf) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/regfile_sb.sv
// Register file with a per-register pending-writeback scoreboard and a decode hazard output.
// Optional same-cycle writeback forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int WIDTH    = regfile_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] writeData,
  input  logic             writeEn,
  input  logic [SEL_W-1:0] writeReg,
  input  logic             issueEn,
  input  logic [SEL_W-1:0] issueReg,
  input  logic [SEL_W-1:0] read1RegSel,
  input  logic [SEL_W-1:0] read2RegSel,
  input  logic             read1Use,
  input  logic             read2Use,
  output logic [WIDTH-1:0] read1Data,
  output logic [WIDTH-1:0] read2Data,
  output logic             hazard,
  output logic             err
);

  logic [WIDTH-1:0]    r_regs [NUM_REGS];
  logic [CNT_W-1:0]    w_count [NUM_REGS];
  logic [NUM_REGS-1:0] w_ovf;
  logic [NUM_REGS-1:0] w_udf;
  logic                r_err;
  logic                w_haz1;
  logic                w_haz2;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
    sb_counter u_cnt (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_inc   (issueEn && (issueReg == SEL_W'(g))),
      .i_dec   (writeEn && (writeReg == SEL_W'(g))),
      .o_count (w_count[g]),
      .o_ovf   (w_ovf[g]),
      .o_udf   (w_udf[g])
    );
  end

  // Underflowing writebacks still store their data; only the count saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (writeEn) begin
      r_regs[writeReg] <= writeData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= r_err | (|w_ovf) | (|w_udf);
  end

  always_comb begin
    read1Data = r_regs[read1RegSel];
    read2Data = r_regs[read2RegSel];
    w_haz1    = read1Use && (w_count[read1RegSel] != '0);
    w_haz2    = read2Use && (w_count[read2RegSel] != '0);
`ifdef REGFILE_BYPASS_EN
    // The last outstanding writeback landing this cycle resolves the hazard.
    if (writeEn && (writeReg == read1RegSel)) begin
      read1Data = writeData;
      if (w_count[read1RegSel] == CNT_W'(1)) w_haz1 = 1'b0;
    end
    if (writeEn && (writeReg == read2RegSel)) begin
      read2Data = writeData;
      if (w_count[read2RegSel] == CNT_W'(1)) w_haz2 = 1'b0;
    end
`endif
  end

  assign hazard = w_haz1 | w_haz2;
  assign err    = r_err;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb; expectations follow REGFILE_BYPASS_EN if defined.
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] writeData;
  logic        writeEn;
  logic [2:0]  writeReg;
  logic        issueEn;
  logic [2:0]  issueReg;
  logic [2:0]  read1RegSel, read2RegSel;
  logic        read1Use, read2Use;
  logic [15:0] read1Data, read2Data;
  logic        hazard, err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk         (clk),
    .rst         (rst),
    .writeData   (writeData),
    .writeEn     (writeEn),
    .writeReg    (writeReg),
    .issueEn     (issueEn),
    .issueReg    (issueReg),
    .read1RegSel (read1RegSel),
    .read2RegSel (read2RegSel),
    .read1Use    (read1Use),
    .read2Use    (read2Use),
    .read1Data   (read1Data),
    .read2Data   (read2Data),
    .hazard      (hazard),
    .err         (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance through one rising edge, then let combinational outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; writeEn = 1'b0; writeData = '0; writeReg = '0;
    issueEn = 1'b0; issueReg = '0;
    read1Use = 1'b0; read2Use = 1'b0;
    read1RegSel = '0; read2RegSel = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic issue(input logic [2:0] r);
    issueEn = 1'b1; issueReg = r;
    tick();
    issueEn = 1'b0;
  endtask

  task automatic wb(input logic [2:0] r, input logic [15:0] d);
    writeEn = 1'b1; writeReg = r; writeData = d;
    tick();
    writeEn = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset then reads
    read1RegSel = 3'd3; read2RegSel = 3'd5; read1Use = 1'b1; read2Use = 1'b1;
    #1;
    chk("rst_rd1", read1Data, 32'h0000);
    chk("rst_rd2", read2Data, 32'h0000);
    chk("rst_haz", hazard, 0);
    chk("rst_err", err, 0);

    // Issue R2 then writeback 0xBEEF
    idle();
    issue(3'd2);
    read1RegSel = 3'd2; read1Use = 1'b1;
    #1;
    chk("iw_haz_c1", hazard, 1);
    tick();
    chk("iw_haz_c2", hazard, 1);
    tick();
    writeEn = 1'b1; writeReg = 3'd2; writeData = 16'hBEEF;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("iw_haz_c3", hazard, 0);
    chk("iw_rd_c3", read1Data, 32'hBEEF);
`else
    chk("iw_haz_c3", hazard, 1);
    chk("iw_rd_c3", read1Data, 32'h0000);
`endif
    tick();
    writeEn = 1'b0;
    #1;
    chk("iw_haz_c4", hazard, 0);
    chk("iw_rd_c4", read1Data, 32'hBEEF);
    chk("iw_err_c4", err, 0);

    // Overflow on R7
    idle();
    issue(3'd7); issue(3'd7); issue(3'd7);
    read2RegSel = 3'd7; read2Use = 1'b1;
    #1;
    chk("ovf_haz3", hazard, 1);
    chk("ovf_err3", err, 0);
    issueEn = 1'b1; issueReg = 3'd7;
    #1;
    chk("ovf_err_pre", err, 0);
    tick();
    issueEn = 1'b0;
    #1;
    chk("ovf_err", err, 1);
    // Count must still be 3: two writebacks leave one pending, the third clears it.
    wb(3'd7, 16'h0001); wb(3'd7, 16'h0002);
    #1;
    chk("ovf_cnt1_haz", hazard, 1);
    wb(3'd7, 16'h0003);
    #1;
    chk("ovf_cnt0_haz", hazard, 0);
    chk("ovf_rd", read2Data, 32'h0003);
    chk("ovf_err_sticky", err, 1);

    // Underflow write to R4 still stores data
    do_reset();
    writeEn = 1'b1; writeReg = 3'd4; writeData = 16'h1234;
    #1;
    chk("udf_err_pre", err, 0);
    tick();
    idle();
    read1RegSel = 3'd4;
    #1;
    chk("udf_rd", read1Data, 32'h1234);
    chk("udf_err", err, 1);

    // Simultaneous issue and writeback to R1 at count 1
    do_reset();
    issue(3'd1);
    issueEn = 1'b1; issueReg = 3'd1;
    writeEn = 1'b1; writeReg = 3'd1; writeData = 16'h5555;
    tick();
    idle();
    read1RegSel = 3'd1; read1Use = 1'b1;
    #1;
    chk("sim_haz_r1", hazard, 1);
    chk("sim_rd", read1Data, 32'h5555);
    chk("sim_err", err, 0);
    read1Use = 1'b0;
    #1;
    chk("sim_haz_nouse", hazard, 0);
    read2RegSel = 3'd1; read2Use = 1'b1;
    #1;
    chk("sim_haz_r2", hazard, 1);
    wb(3'd1, 16'h6666);
    #1;
    chk("sim_cnt0_haz", hazard, 0);

    // Reset with pending counts, err set and a writeback in flight
    do_reset();
    issue(3'd3);
    issue(3'd6);
    wb(3'd5, 16'hAAAA);
    #1;
    chk("rst2_err_pre", err, 1);
    rst = 1'b1;
    writeEn = 1'b1; writeReg = 3'd6; writeData = 16'hFFFF;
    issueEn = 1'b1; issueReg = 3'd2;
    tick();
    idle();
    read1RegSel = 3'd6; read1Use = 1'b1;
    read2RegSel = 3'd3; read2Use = 1'b1;
    #1;
    chk("rst2_rd6", read1Data, 32'h0000);
    chk("rst2_haz", hazard, 0);
    chk("rst2_err", err, 0);
    read2RegSel = 3'd5;
    #1;
    chk("rst2_rd5", read2Data, 32'h0000);
    read1RegSel = 3'd2;
    #1;
    chk("rst2_haz_r2", hazard, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no-finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
